// File: rtl/seq_det_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_det_pkg                                                          |
// | Shared state encoding and pattern-length mask helper for seq_detector|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        SEARCH = 2'd2
    } det_state_t;

    localparam int c_mask_w = 64;

    // Ones in the low 'len' bit positions; callers size-cast to their width.
    function automatic logic [c_mask_w-1:0] len_mask(input int unsigned len);
        logic [c_mask_w-1:0] mask;
        mask = '0;
        for (int i = 0; i < c_mask_w; i++) begin
            mask[i] = (i < len);
        end
        return mask;
    endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_detector_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_detector_if                                                      |
// | Serial stream, configuration and status bundle of seq_detector       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface seq_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               en;
    logic               x;
    logic               x_valid;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               clear_cnt;
    logic               hit;
    logic [CNT_W-1:0]   hit_count;
    logic               cfg_err;
    logic               busy;

    modport master (
        output en, x, x_valid, pattern, pat_len, overlap, clear_cnt,
        input  hit, hit_count, cfg_err, busy
    );

    modport slave (
        input  en, x, x_valid, pattern, pat_len, overlap, clear_cnt,
        output hit, hit_count, cfg_err, busy
    );

endinterface : seq_detector_if
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter                                                          |
// | Saturating up-counter with a synchronous clear that wins over inc    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         clr,
    input  wire logic         inc,
    output logic [W-1:0]      count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_detector                                                         |
// | Mealy serial-pattern detector, programmable length, overlap option   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    seq_detector_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [LEN_W-1:0] c_one     = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

    det_state_t           r_state,   w_state_nxt;
    logic [MAX_LEN-1:0]   r_cfg_pat, w_cfg_pat_nxt;
    logic [LEN_W-1:0]     r_cfg_len, w_cfg_len_nxt;
    logic                 r_cfg_ovl, w_cfg_ovl_nxt;
    logic [MAX_LEN-2:0]   r_hist,    w_hist_nxt;
    logic [LEN_W-1:0]     r_fill,    w_fill_nxt;
    logic                 r_cfg_err, w_cfg_err_nxt;

    logic [MAX_LEN-1:0]   w_window;
    logic [MAX_LEN-1:0]   w_mask;
    logic                 w_match;
    logic                 w_hit;
    logic                 w_len_legal;
    logic [LEN_W-1:0]     w_fill_inc;
    logic [CNT_W-1:0]     w_hit_count;

    // Window is the stored history with the current bit appended as LSB.
    assign w_window    = {r_hist, bus.x};
    assign w_mask      = MAX_LEN'(len_mask(int'(r_cfg_len)));
    assign w_match     = ((w_window ^ r_cfg_pat) & w_mask) == '0;
    assign w_hit       = bus.en && bus.x_valid && (r_state == SEARCH) && w_match;
    assign w_len_legal = (bus.pat_len != '0) && (bus.pat_len <= c_max_len);
    assign w_fill_inc  = r_fill + c_one;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cfg_pat <= '0;
            r_cfg_len <= '0;
            r_cfg_ovl <= 1'b0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_pat <= w_cfg_pat_nxt;
            r_cfg_len <= w_cfg_len_nxt;
            r_cfg_ovl <= w_cfg_ovl_nxt;
            r_hist    <= w_hist_nxt;
            r_fill    <= w_fill_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cfg_pat_nxt = r_cfg_pat;
        w_cfg_len_nxt = r_cfg_len;
        w_cfg_ovl_nxt = r_cfg_ovl;
        w_hist_nxt    = r_hist;
        w_fill_nxt    = r_fill;
        w_cfg_err_nxt = r_cfg_err;

        if (!bus.en) begin
            w_state_nxt = IDLE;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_len_legal) begin
                        w_cfg_pat_nxt = bus.pattern;
                        w_cfg_len_nxt = bus.pat_len;
                        w_cfg_ovl_nxt = bus.overlap;
                        w_hist_nxt    = '0;
                        w_fill_nxt    = '0;
                        w_cfg_err_nxt = 1'b0;
                        w_state_nxt   = (bus.pat_len == c_one) ? SEARCH : FILL;
                    end else begin
                        w_cfg_err_nxt = 1'b1;
                    end
                end
                FILL: begin
                    if (bus.x_valid) begin
                        w_hist_nxt = w_window[MAX_LEN-2:0];
                        w_fill_nxt = w_fill_inc;
                        if (w_fill_inc == (r_cfg_len - c_one)) begin
                            w_state_nxt = SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    if (bus.x_valid) begin
                        w_hist_nxt = w_window[MAX_LEN-2:0];
                        // Non-overlapping mode restarts collection after a hit;
                        // a 1-bit pattern has nothing to collect and stays here.
                        if (w_hit && !r_cfg_ovl && (r_cfg_len != c_one)) begin
                            w_hist_nxt  = '0;
                            w_fill_nxt  = '0;
                            w_state_nxt = FILL;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_hist_nxt  = '0;
                    w_fill_nxt  = '0;
                end
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_hit_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear_cnt),
        .inc   (w_hit),
        .count (w_hit_count)
    );

    assign bus.hit       = w_hit;
    assign bus.hit_count = w_hit_count;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.busy      = (r_state != IDLE);

endmodule : seq_detector
`default_nettype wire

// File: tb/tb_seq_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_detector                                                      |
// | Scoreboard bench for seq_detector with a behavioural reference model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_seq_detector;

    localparam int c_max_len = 8;
    localparam int c_cnt_w   = 2;

    logic clk;
    logic reset;

    seq_detector_if #(.MAX_LEN(c_max_len), .CNT_W(c_cnt_w)) bus ();

    seq_detector #(
        .MAX_LEN (c_max_len),
        .CNT_W   (c_cnt_w)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic sb_q[$];
    logic last_hit;
    logic [15:0] hit_map;

    // reference model state
    logic       m_busy, m_ovl, m_err;
    logic [7:0] m_pat, m_bits;
    logic [1:0] m_cnt;
    int         m_len, m_n;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_ovl = 1'b0; m_err = 1'b0;
        m_pat  = '0;   m_bits = '0;  m_cnt = '0;
        m_len  = 0;    m_n = 0;
    endtask

    function automatic logic model_hit(input logic e, input logic b, input logic v);
        logic [7:0] w;
        logic [7:0] msk;
        w   = {m_bits[6:0], b};
        msk = 8'((16'd1 << m_len) - 16'd1);
        return m_busy && e && v && (m_n + 1 >= m_len) && ((w & msk) == (m_pat & msk));
    endfunction

    // One clock: drive at negedge, compare, advance model at posedge, return at negedge.
    task automatic step(input logic e, input logic b, input logic v, input logic c);
        logic eh;
        bus.en = e; bus.x = b; bus.x_valid = v; bus.clear_cnt = c;
        check("hit_count", 32'(bus.hit_count), 32'(m_cnt));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("cfg_err", 32'(bus.cfg_err), 32'(m_err));
        eh = model_hit(e, b, v);
        sb_q.push_back(eh);
        #1;
        last_hit = bus.hit;
        check("hit", 32'(bus.hit), 32'(sb_q.pop_front()));
        @(posedge clk);
        if (c) m_cnt = '0;
        else if (eh && m_cnt != 2'b11) m_cnt = m_cnt + 2'd1;
        if (!e) begin
            m_busy = 1'b0; m_n = 0;
        end else if (!m_busy) begin
            if (bus.pat_len != 0 && int'(bus.pat_len) <= c_max_len) begin
                m_busy = 1'b1; m_pat = bus.pattern; m_len = int'(bus.pat_len);
                m_ovl  = bus.overlap; m_n = 0; m_bits = '0; m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (v) begin
            m_bits = {m_bits[6:0], b};
            m_n    = (eh && !m_ovl) ? 0 : m_n + 1;
        end
        @(negedge clk);
    endtask

    // Sends n valid bits, first bit taken from bits[n-1]; records observed hits.
    task automatic send(input logic [15:0] bits, input int n);
        hit_map = '0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, bits[n-1-i], 1'b1, 1'b0);
            hit_map[i] = last_hit;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.x_valid = 1'b0; bus.clear_cnt = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0; bus.en = 1'b0;
    endtask

    task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic o);
        bus.pattern = p; bus.pat_len = l; bus.overlap = o;
    endtask

    initial begin
        reset = 1'b1;
        bus.en = 1'b0; bus.x = 1'b0; bus.x_valid = 1'b0; bus.clear_cnt = 1'b0;
        configure(8'h00, 4'd0, 1'b0);
        model_reset();
        last_hit = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_hit_count", 32'(bus.hit_count), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_cfg_err", 32'(bus.cfg_err), 0);
        check("rst_hit", 32'(bus.hit), 0);

        // overlapping
        configure(8'b0000_1011, 4'd4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("ovl_busy", 32'(bus.busy), 1);
        send(16'b101_1011, 7);
        check("ovl_hits", 32'(hit_map), 32'h48);
        check("ovl_cnt", 32'(bus.hit_count), 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_cnt", 32'(bus.hit_count), 0);

        // non-overlapping
        configure(8'b0000_1011, 4'd4, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send(16'b101_1011, 7);
        check("novl_hits", 32'(hit_map), 32'h08);
        check("novl_cnt", 32'(bus.hit_count), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // single-bit pattern
        configure(8'h01, 4'd1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send(16'b1101, 4);
        check("len1_hits", 32'(hit_map), 32'h0B);
        check("len1_cnt", 32'(bus.hit_count), 3);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // illegal lengths
        configure(8'h05, 4'd0, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("ill_busy", 32'(bus.busy), 0);
        check("ill_err", 32'(bus.cfg_err), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ill_err_hold", 32'(bus.cfg_err), 1);
        configure(8'h05, 4'd3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("legal_err", 32'(bus.cfg_err), 0);
        check("legal_busy", 32'(bus.busy), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        configure(8'h05, 4'd9, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("ill9_err", 32'(bus.cfg_err), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // saturation, then clear coincident with a hit
        configure(8'h01, 4'd1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send(16'b1_1111, 5);
        check("sat_cnt", 32'(bus.hit_count), 3);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_hit_seen", 32'(last_hit), 1);
        check("clr_hit_cnt", 32'(bus.hit_count), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // stalls inside a pattern; config changes while busy are ignored
        configure(8'b0000_1011, 4'd4, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        configure(8'h00, 4'd2, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("stall_hit", 32'(last_hit), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // enable dropped on the completing bit, then a fresh pattern
        configure(8'b0000_1011, 4'd4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send(16'b101, 3);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("abort_hit", 32'(last_hit), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send(16'b1, 1);
        check("abort_nohit", 32'(last_hit), 0);
        send(16'b011, 3);
        check("abort_rehit", 32'(hit_map), 32'h04);

        // reset mid-pattern with enable held high
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send(16'b101, 3);
        bus.en = 1'b1;
        do_reset();
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_cnt", 32'(bus.hit_count), 0);
        configure(8'b0000_1011, 4'd4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send(16'b1, 1);
        check("mid_rst_nohit", 32'(last_hit), 0);

        // randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic e, v, c;
            if ($urandom_range(0, 19) == 0) begin
                configure(8'($urandom), ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15) % 10)
                                                                   : 4'($urandom_range(1, 4)),
                          1'($urandom));
            end
            e = ($urandom_range(0, 29) != 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 24) == 0);
            step(e, 1'($urandom), v, c);
        end

        step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_seq_detector
`default_nettype wire
